// File: rtl/execute_sys_reg_commit.sv
// Commit stage for IDT/PDT/PSR writes from the execute-stage system-register unit.
// A flagged write triggers a flush/reload handshake so fetch restarts under the new context.
module execute_sys_reg_commit #(
    parameter logic [31:0] PSR_RESET = 32'h0000_0000,
    parameter logic [31:0] IDT_RESET = 32'h0000_0000,
    parameter logic [31:0] PDT_RESET = 32'h0000_0000
) (
    input  logic        iCLOCK,
    input  logic        inRESET,
    input  logic        iFREE,
    input  logic        iVALID,
    output logic        oBUSY,
    input  logic [31:0] iDATA,
    input  logic        iIDT_VALID,
    input  logic        iPDT_VALID,
    input  logic        iPSR_VALID,
    input  logic [31:0] iRELOAD_ADDR,
    output logic        oFLUSH_REQ,
    input  logic        iFLUSH_ACK,
    output logic        oRELOAD_VALID,
    output logic [31:0] oRELOAD_ADDR,
    output logic [31:0] oIDT,
    output logic [31:0] oPDT,
    output logic [31:0] oPSR
);

    typedef enum logic [1:0] {StIdle, StFlush, StReload} state_t;

    state_t      state_q;
    logic        flush_req_q;
    logic        reload_valid_q;
    logic [31:0] reload_addr_q;
    logic [31:0] idt_q;
    logic [31:0] pdt_q;
    logic [31:0] psr_q;
    logic        any_flag;

    assign any_flag = iIDT_VALID | iPDT_VALID | iPSR_VALID;

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state_q        <= StIdle;
            flush_req_q    <= 1'b0;
            reload_valid_q <= 1'b0;
            reload_addr_q  <= 32'h0000_0000;
            idt_q          <= IDT_RESET;
            pdt_q          <= PDT_RESET;
            psr_q          <= PSR_RESET;
        end else if (iFREE) begin
            // Abort: drop the handshake but keep any register already written.
            state_q        <= StIdle;
            flush_req_q    <= 1'b0;
            reload_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    reload_valid_q <= 1'b0;
                    if (iVALID) begin
                        reload_addr_q <= iRELOAD_ADDR;
                        if (iPSR_VALID) begin
                            psr_q <= iDATA;
                        end else if (iPDT_VALID) begin
                            pdt_q <= iDATA;
                        end else if (iIDT_VALID) begin
                            idt_q <= iDATA;
                        end
                        if (any_flag) begin
                            state_q     <= StFlush;
                            flush_req_q <= 1'b1;
                        end
                    end
                end
                StFlush: begin
                    if (iFLUSH_ACK) begin
                        state_q        <= StReload;
                        flush_req_q    <= 1'b0;
                        reload_valid_q <= 1'b1;
                    end
                end
                StReload: begin
                    state_q        <= StIdle;
                    reload_valid_q <= 1'b0;
                end
                default: begin
                    state_q        <= StIdle;
                    flush_req_q    <= 1'b0;
                    reload_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign oBUSY         = (state_q != StIdle);
    assign oFLUSH_REQ    = flush_req_q;
    assign oRELOAD_VALID = reload_valid_q;
    assign oRELOAD_ADDR  = reload_addr_q;
    assign oIDT          = idt_q;
    assign oPDT          = pdt_q;
    assign oPSR          = psr_q;

endmodule

// File: tb/tb_execute_sys_reg_commit.sv
// Directed bench for execute_sys_reg_commit: vector table plus hand sequences for
// stall-while-busy, iFREE abort and mid-flush reset.
module tb_execute_sys_reg_commit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        free, valid, busy, idt_v, pdt_v, psr_v, ack, flush, rel;
    logic [31:0] data, raddr_in, raddr_out, idt, pdt, psr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    execute_sys_reg_commit dut (
        .iCLOCK       (clk),
        .inRESET      (rst_n),
        .iFREE        (free),
        .iVALID       (valid),
        .oBUSY        (busy),
        .iDATA        (data),
        .iIDT_VALID   (idt_v),
        .iPDT_VALID   (pdt_v),
        .iPSR_VALID   (psr_v),
        .iRELOAD_ADDR (raddr_in),
        .oFLUSH_REQ   (flush),
        .iFLUSH_ACK   (ack),
        .oRELOAD_VALID(rel),
        .oRELOAD_ADDR (raddr_out),
        .oIDT         (idt),
        .oPDT         (pdt),
        .oPSR         (psr)
    );

    typedef struct {
        logic        valid, idt_v, pdt_v, psr_v, ack, free;
        logic [31:0] data, addr;
        logic        e_busy, e_flush, e_rel;
        logic [31:0] e_addr, e_idt, e_pdt, e_psr;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic v, logic fi, logic fp, logic fs, logic a, logic f,
                                logic [31:0] d, logic [31:0] ad, logic eb, logic ef,
                                logic er, logic [31:0] ea, logic [31:0] ei,
                                logic [31:0] ep, logic [31:0] es);
        vec_t x;
        x.valid = v;  x.idt_v = fi; x.pdt_v = fp; x.psr_v = fs; x.ack = a; x.free = f;
        x.data = d;   x.addr = ad;  x.e_busy = eb; x.e_flush = ef; x.e_rel = er;
        x.e_addr = ea; x.e_idt = ei; x.e_pdt = ep; x.e_psr = es;
        vecs.push_back(x);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        valid = 0; idt_v = 0; pdt_v = 0; psr_v = 0; ack = 0; free = 0;
        data = 32'h0; raddr_in = 32'h0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ctl(input string name, input logic eb, input logic ef, input logic er);
        chk({name, ".busy"}, {31'h0, busy}, {31'h0, eb});
        chk({name, ".flush"}, {31'h0, flush}, {31'h0, ef});
        chk({name, ".reload"}, {31'h0, rel}, {31'h0, er});
    endtask

    initial begin
        bit seen;
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        chk_ctl("reset", 0, 0, 0);
        chk("reset.idt", idt, 32'h0);
        chk("reset.pdt", pdt, 32'h0);
        chk("reset.psr", psr, 32'h0);
        chk("reset.addr", raddr_out, 32'h0);

        //   v fi fp fs ak fr data           addr           b  f  r  eaddr          idt  pdt         psr
        add(1, 0, 0, 1, 0, 0, 32'h65,        32'h1004,      1, 1, 0, 32'h0,         0,   0,          32'h65);
        add(0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         1, 1, 0, 32'h0,         0,   0,          32'h65);
        add(0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         1, 1, 0, 32'h0,         0,   0,          32'h65);
        add(0, 0, 0, 0, 1, 0, 32'h0,         32'h0,         1, 0, 1, 32'h1004,      0,   0,          32'h65);
        add(0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         0, 0, 0, 32'h0,         0,   0,          32'h65);
        for (int i = 0; i < 4; i++)
            add(1, 0, 0, 0, 0, 0, 32'h1234,  32'h9999,      0, 0, 0, 32'h0,         0,   0,          32'h65);
        add(0, 0, 0, 0, 1, 0, 32'h0,         32'h0,         0, 0, 0, 32'h0,         0,   0,          32'h65);
        add(1, 1, 0, 0, 0, 1, 32'h77,        32'h7000,      0, 0, 0, 32'h0,         0,   0,          32'h65);
        add(1, 0, 1, 1, 0, 0, 32'h8000_0000, 32'h2000,      1, 1, 0, 32'h0,         0,   0,          32'h8000_0000);
        add(0, 0, 0, 0, 1, 0, 32'h0,         32'h0,         1, 0, 1, 32'h2000,      0,   0,          32'h8000_0000);
        add(0, 0, 0, 0, 1, 0, 32'h0,         32'h0,         0, 0, 0, 32'h0,         0,   0,          32'h8000_0000);
        add(1, 0, 1, 0, 1, 0, 32'h5555,      32'h3000,      1, 1, 0, 32'h0,         0,   32'h5555,   32'h8000_0000);
        add(0, 0, 0, 0, 1, 0, 32'h0,         32'h0,         1, 0, 1, 32'h3000,      0,   32'h5555,   32'h8000_0000);
        add(0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         0, 0, 0, 32'h0,         0,   32'h5555,   32'h8000_0000);

        foreach (vecs[i]) begin
            string n;
            n = $sformatf("vec%0d", i);
            valid = vecs[i].valid; idt_v = vecs[i].idt_v; pdt_v = vecs[i].pdt_v;
            psr_v = vecs[i].psr_v; ack = vecs[i].ack; free = vecs[i].free;
            data = vecs[i].data; raddr_in = vecs[i].addr;
            step();
            chk_ctl(n, vecs[i].e_busy, vecs[i].e_flush, vecs[i].e_rel);
            chk({n, ".idt"}, idt, vecs[i].e_idt);
            chk({n, ".pdt"}, pdt, vecs[i].e_pdt);
            chk({n, ".psr"}, psr, vecs[i].e_psr);
            if (vecs[i].e_rel) chk({n, ".addr"}, raddr_out, vecs[i].e_addr);
        end
        idle_inputs();

        // IDT write held upstream while a PDT flush is in progress
        valid = 1; pdt_v = 1; data = 32'h777; raddr_in = 32'h4000;
        step();
        chk_ctl("hold.acc", 1, 1, 0);
        chk("hold.pdt", pdt, 32'h777);
        pdt_v = 0; idt_v = 1; data = 32'hAAAA_0000; raddr_in = 32'h5000;
        for (int i = 0; i < 2; i++) begin
            step();
            chk_ctl("hold.flush", 1, 1, 0);
            chk("hold.idt", idt, 32'h0);
        end
        ack = 1;
        step();
        chk_ctl("hold.reload", 1, 0, 1);
        chk("hold.addr", raddr_out, 32'h4000);
        chk("hold.idt_r", idt, 32'h0);
        ack = 0;
        step();
        chk_ctl("hold.idle", 0, 0, 0);
        chk("hold.idt_i", idt, 32'h0);
        step();
        chk_ctl("hold.acc2", 1, 1, 0);
        chk("hold.idt_w", idt, 32'hAAAA_0000);
        idle_inputs();
        ack = 1;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            if (rel) seen = 1;
        end
        chk("hold.seq2_reload", {31'h0, seen}, 32'h1);
        chk("hold.seq2_addr", raddr_out, 32'h5000);
        ack = 0;
        step();
        chk_ctl("hold.end", 0, 0, 0);

        // iFREE during FLUSH
        valid = 1; idt_v = 1; data = 32'h1111_1111; raddr_in = 32'h6000;
        step();
        idle_inputs();
        step();
        chk_ctl("free.pre", 1, 1, 0);
        free = 1;
        step();
        chk_ctl("free.abort", 0, 0, 0);
        chk("free.idt", idt, 32'h1111_1111);
        free = 0; ack = 1;
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (rel || flush) seen = 1;
        end
        chk("free.no_reload", {31'h0, seen}, 32'h0);
        idle_inputs();

        // Asynchronous reset during FLUSH
        valid = 1; psr_v = 1; data = 32'h2222; raddr_in = 32'h7000;
        step();
        idle_inputs();
        chk_ctl("rst.pre", 1, 1, 0);
        #2 rst_n = 1'b0;
        #1;
        chk_ctl("rst.async", 0, 0, 0);
        chk("rst.idt", idt, 32'h0);
        chk("rst.pdt", pdt, 32'h0);
        chk("rst.psr", psr, 32'h0);
        chk("rst.addr", raddr_out, 32'h0);
        step();
        rst_n = 1'b1;
        ack = 1;
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (rel || flush || busy) seen = 1;
        end
        chk("rst.no_reload", {31'h0, seen}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
